// File: rtl/rvfi_commit_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_commit_monitor_if
// Brief    : Retire-stage to commit-monitor bundle: strobes and PCs in,
//            order numbers and halt status out.
// Revision : 1.0 - initial release
// ============================================================================
interface rvfi_commit_monitor_if #(
    parameter int NUM_CH  = 1,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
);
    logic [NUM_CH-1:0]         commit_valid;
    logic [NUM_CH*XLEN-1:0]    pc_rdata;
    logic [NUM_CH*XLEN-1:0]    pc_wdata;
    logic [NUM_CH*ORDER_W-1:0] order;
    logic [ORDER_W-1:0]        order_base;
    logic                      armed;
    logic                      halt;
    logic [XLEN-1:0]           halt_pc;

    modport master (
        output commit_valid, pc_rdata, pc_wdata,
        input  order, order_base, armed, halt, halt_pc
    );

    modport slave (
        input  commit_valid, pc_rdata, pc_wdata,
        output order, order_base, armed, halt, halt_pc
    );
endinterface
`default_nettype wire

// File: rtl/rvfi_commit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_commit_monitor
// Brief    : Multi-channel RVFI commit order counter and jump-to-self halt
//            detector with confirm count and programmable halt delay.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_commit_monitor #(
    parameter int NUM_CH       = 1,
    parameter int XLEN         = 32,
    parameter int ORDER_W      = 64,
    parameter int HALT_CONFIRM = 1,
    parameter int HALT_DELAY   = 2
) (
    input wire logic               clk,
    input wire logic               rst,
    rvfi_commit_monitor_if.slave   bus
);

    localparam int c_CNT_W = $clog2(HALT_CONFIRM + 1);
    localparam int c_DLY_W = (HALT_DELAY > 1) ? $clog2(HALT_DELAY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ARM  = c_CNT_W'(HALT_CONFIRM - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(HALT_CONFIRM);
    localparam logic [c_DLY_W-1:0] c_DLY_ONE  = c_DLY_W'(1);
    localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'((HALT_DELAY > 0) ? HALT_DELAY - 1 : 0);

    if (HALT_CONFIRM < 1) begin : g_bad_confirm
        $error("rvfi_commit_monitor: HALT_CONFIRM must be >= 1");
    end
    if (HALT_DELAY < 0) begin : g_bad_delay
        $error("rvfi_commit_monitor: HALT_DELAY must be >= 0");
    end

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               r_state;
    logic [ORDER_W-1:0]   r_order_base;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_DLY_W-1:0]   r_dly;
    logic [XLEN-1:0]      r_cand;
    logic [XLEN-1:0]      r_halt_pc;
    logic                 r_armed;
    logic                 r_halt;

    logic [NUM_CH*ORDER_W-1:0] w_order;
    logic [ORDER_W-1:0]        w_acc;
    logic [ORDER_W-1:0]        w_next_base;
    logic [XLEN-1:0]           w_dec_rd;
    logic [XLEN-1:0]           w_dec_wd;
    logic                      w_any;
    logic                      w_loop;
    logic                      w_nonloop;

    // Prefix-count the strobes; the last valid channel seen is the youngest
    // retirement and therefore decides the loop classification.
    always_comb begin
        w_acc    = r_order_base;
        w_order  = '0;
        w_any    = 1'b0;
        w_dec_rd = '0;
        w_dec_wd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_order[c*ORDER_W +: ORDER_W] = w_acc;
            w_acc = w_acc + ORDER_W'(bus.commit_valid[c]);
            if (bus.commit_valid[c]) begin
                w_any    = 1'b1;
                w_dec_rd = bus.pc_rdata[c*XLEN +: XLEN];
                w_dec_wd = bus.pc_wdata[c*XLEN +: XLEN];
            end
        end
        w_next_base = w_acc;
    end

    assign w_loop    = w_any && (w_dec_rd == w_dec_wd);
    assign w_nonloop = w_any && (w_dec_rd != w_dec_wd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_order_base <= '0;
            r_cnt        <= '0;
            r_dly        <= '0;
            r_cand       <= '0;
            r_halt_pc    <= '0;
            r_armed      <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            r_order_base <= w_next_base;
            case (r_state)
                ST_RUN: begin
                    if (w_loop) begin
                        r_cand <= w_dec_rd;
                        if (r_cnt == c_CNT_ARM) begin
                            r_cnt <= c_CNT_FULL;
                            if (HALT_DELAY == 0) begin
                                r_state   <= ST_HALTED;
                                r_halt    <= 1'b1;
                                r_halt_pc <= w_dec_rd;
                            end else begin
                                r_state <= ST_ARMED;
                                r_armed <= 1'b1;
                                r_dly   <= c_DLY_LOAD;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end else if (w_nonloop) begin
                        r_cnt <= '0;
                    end
                end
                ST_ARMED: begin
                    // An abort in the final delay cycle takes priority over halting.
                    if (w_nonloop) begin
                        r_state <= ST_RUN;
                        r_armed <= 1'b0;
                        r_cnt   <= '0;
                        r_dly   <= '0;
                    end else if (r_dly == '0) begin
                        r_state   <= ST_HALTED;
                        r_armed   <= 1'b0;
                        r_halt    <= 1'b1;
                        r_halt_pc <= r_cand;
                    end else begin
                        r_dly <= r_dly - c_DLY_ONE;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_armed <= 1'b0;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.order      = w_order;
    assign bus.order_base = r_order_base;
    assign bus.armed      = r_armed;
    assign bus.halt       = r_halt;
    assign bus.halt_pc    = r_halt_pc;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_commit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_commit_monitor
// Brief    : Three monitor configurations driven by directed and random
//            commits, compared against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_commit_monitor;

    localparam int c_NI = 3;
    localparam int c_NCH [c_NI] = '{1, 4, 2};
    localparam int c_OW  [c_NI] = '{64, 6, 4};
    localparam int c_HC  [c_NI] = '{1, 3, 2};
    localparam int c_HD  [c_NI] = '{2, 3, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  v  [c_NI];
    logic [31:0] rd [c_NI][4];
    logic [31:0] wd [c_NI][4];

    logic [63:0] obs_ord   [c_NI][4];
    logic [63:0] obs_base  [c_NI];
    logic        obs_armed [c_NI];
    logic        obs_halt  [c_NI];
    logic [31:0] obs_hpc   [c_NI];

    rvfi_commit_monitor_if #(.NUM_CH(1), .XLEN(32), .ORDER_W(64)) bus0 ();
    rvfi_commit_monitor_if #(.NUM_CH(4), .XLEN(32), .ORDER_W(6))  bus1 ();
    rvfi_commit_monitor_if #(.NUM_CH(2), .XLEN(32), .ORDER_W(4))  bus2 ();

    assign bus0.commit_valid = v[0][0:0];
    assign bus0.pc_rdata     = rd[0][0];
    assign bus0.pc_wdata     = wd[0][0];
    assign bus1.commit_valid = v[1];
    assign bus1.pc_rdata     = {rd[1][3], rd[1][2], rd[1][1], rd[1][0]};
    assign bus1.pc_wdata     = {wd[1][3], wd[1][2], wd[1][1], wd[1][0]};
    assign bus2.commit_valid = v[2][1:0];
    assign bus2.pc_rdata     = {rd[2][1], rd[2][0]};
    assign bus2.pc_wdata     = {wd[2][1], wd[2][0]};

    rvfi_commit_monitor u0 (.clk(clk), .rst(rst), .bus(bus0));
    rvfi_commit_monitor #(.NUM_CH(4), .XLEN(32), .ORDER_W(6), .HALT_CONFIRM(3), .HALT_DELAY(3))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    rvfi_commit_monitor #(.NUM_CH(2), .XLEN(32), .ORDER_W(4), .HALT_CONFIRM(2), .HALT_DELAY(0))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    always_comb begin
        for (int i = 0; i < c_NI; i++)
            for (int c = 0; c < 4; c++)
                obs_ord[i][c] = '0;
        obs_ord[0][0] = bus0.order;
        for (int c = 0; c < 4; c++)
            obs_ord[1][c] = 64'(bus1.order[c*6 +: 6]);
        for (int c = 0; c < 2; c++)
            obs_ord[2][c] = 64'(bus2.order[c*4 +: 4]);
        obs_base[0]  = bus0.order_base;
        obs_base[1]  = 64'(bus1.order_base);
        obs_base[2]  = 64'(bus2.order_base);
        obs_armed[0] = bus0.armed;
        obs_armed[1] = bus1.armed;
        obs_armed[2] = bus2.armed;
        obs_halt[0]  = bus0.halt;
        obs_halt[1]  = bus1.halt;
        obs_halt[2]  = bus2.halt;
        obs_hpc[0]   = bus0.halt_pc;
        obs_hpc[1]   = bus1.halt_pc;
        obs_hpc[2]   = bus2.halt_pc;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, commit total, loop streak, arm time.
    logic [63:0] m_base   [c_NI];
    int          m_streak [c_NI];
    bit          m_armed  [c_NI];
    bit          m_halted [c_NI];
    int          m_t0     [c_NI];
    logic [31:0] m_cand   [c_NI];
    logic [31:0] m_hpc    [c_NI];
    int          t_edge = 0;

    function automatic logic [63:0] msk(input int i);
        return (c_OW[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << c_OW[i]) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_NI; i++) begin
            m_base[i] = '0; m_streak[i] = 0; m_armed[i] = 0; m_halted[i] = 0;
            m_t0[i] = 0; m_cand[i] = '0; m_hpc[i] = '0;
        end
    endtask

    task automatic model_step(input int i);
        int n = 0;
        int hi = -1;
        bit is_loop, is_non;
        for (int c = 0; c < c_NCH[i]; c++)
            if (v[i][c]) begin n++; hi = c; end
        m_base[i] = (m_base[i] + 64'(n)) & msk(i);
        is_loop = (hi >= 0) && (rd[i][hi] == wd[i][hi]);
        is_non  = (hi >= 0) && (rd[i][hi] != wd[i][hi]);
        if (m_halted[i]) begin
        end else if (m_armed[i]) begin
            if (is_non) begin
                m_armed[i] = 0; m_streak[i] = 0;
            end else if (t_edge - m_t0[i] == c_HD[i]) begin
                m_armed[i] = 0; m_halted[i] = 1; m_hpc[i] = m_cand[i];
            end
        end else if (is_loop) begin
            m_streak[i]++;
            m_cand[i] = rd[i][hi];
            if (m_streak[i] == c_HC[i]) begin
                if (c_HD[i] == 0) begin
                    m_halted[i] = 1; m_hpc[i] = rd[i][hi];
                end else begin
                    m_armed[i] = 1; m_t0[i] = t_edge;
                end
            end
        end else if (is_non) begin
            m_streak[i] = 0;
        end
    endtask

    task automatic settle();
        #1;
        if (!rst) begin
            for (int i = 0; i < c_NI; i++) begin
                int n = 0;
                for (int c = 0; c < c_NCH[i]; c++) begin
                    chk($sformatf("u%0d_order%0d", i, c), obs_ord[i][c], (m_base[i] + 64'(n)) & msk(i));
                    if (v[i][c]) n++;
                end
            end
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < c_NI; i++) model_step(i);
        t_edge++;
        #1;
        for (int i = 0; i < c_NI; i++) begin
            chk($sformatf("u%0d_base", i),   obs_base[i], m_base[i]);
            chk($sformatf("u%0d_armed", i),  64'(obs_armed[i]), 64'(m_armed[i]));
            chk($sformatf("u%0d_halt", i),   64'(obs_halt[i]), 64'(m_halted[i]));
            chk($sformatf("u%0d_haltpc", i), 64'(obs_hpc[i]), 64'(m_hpc[i]));
        end
    endtask

    task automatic cycle();
        settle();
        clock_edge();
    endtask

    task automatic idle_all();
        for (int i = 0; i < c_NI; i++) begin
            v[i] = '0;
            for (int c = 0; c < 4; c++) begin rd[i][c] = '0; wd[i][c] = 32'd4; end
        end
    endtask

    task automatic put(input int i, input int c, input logic [31:0] pc, input bit self);
        v[i][c]  = 1'b1;
        rd[i][c] = pc;
        wd[i][c] = self ? pc : pc + 32'd4;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        idle_all();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_base", obs_base[0], 64'd0);

        // Five straight-line commits on the single-channel instance.
        for (int k = 0; k < 5; k++) begin
            idle_all();
            put(0, 0, 32'h100 + 32'(k) * 4, 1'b0);
            settle();
            chk("seq_order", obs_ord[0][0], 64'(k));
            clock_edge();
        end
        chk("seq_base", obs_base[0], 64'd5);
        chk("seq_halt", 64'(obs_halt[0]), 64'd0);

        // Bring the 4-channel base to 10, then a sparse 1011 pattern.
        idle_all(); v[1] = 4'b1111; cycle(); cycle();
        idle_all(); v[1] = 4'b0011; cycle();
        idle_all(); v[1] = 4'b1011;
        settle();
        chk("sparse_o0", obs_ord[1][0], 64'd10);
        chk("sparse_o1", obs_ord[1][1], 64'd11);
        chk("sparse_o3", obs_ord[1][3], 64'd12);
        clock_edge();
        chk("sparse_base", obs_base[1], 64'd13);

        // Idle gap, single self-loop at 0x60, delay of two cycles.
        do_reset();
        idle_all(); cycle(); cycle(); cycle();
        put(0, 0, 32'h60, 1'b1); cycle();
        chk("arm_e0", 64'(obs_armed[0]), 64'd1);
        idle_all(); cycle();
        chk("arm_e1", 64'(obs_armed[0]), 64'd1);
        chk("halt_e1", 64'(obs_halt[0]), 64'd0);
        cycle();
        chk("arm_e2", 64'(obs_armed[0]), 64'd0);
        chk("halt_e2", 64'(obs_halt[0]), 64'd1);
        chk("haltpc_e2", 64'(obs_hpc[0]), 64'h60);

        // Confirm-3 pattern: L L N L L L arms only after the sixth commit.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            idle_all();
            put(1, 0, 32'h200, k != 2);
            cycle();
            chk($sformatf("confirm_arm%0d", k), 64'(obs_armed[1]), (k == 5) ? 64'd1 : 64'd0);
        end

        // Abort while armed; lower NONLOOP under a higher LOOP counts as LOOP.
        do_reset();
        idle_all();
        put(0, 0, 32'h300, 1'b1);
        put(2, 0, 32'h400, 1'b0); put(2, 1, 32'h404, 1'b1);
        cycle();
        chk("abort_arm", 64'(obs_armed[0]), 64'd1);
        chk("mixed_halt1", 64'(obs_halt[2]), 64'd0);
        idle_all();
        put(0, 0, 32'h304, 1'b0);
        put(2, 0, 32'h400, 1'b0); put(2, 1, 32'h404, 1'b1);
        cycle();
        chk("abort_drop", 64'(obs_armed[0]), 64'd0);
        chk("mixed_halt2", 64'(obs_halt[2]), 64'd1);
        chk("mixed_hpc", 64'(obs_hpc[2]), 64'h404);
        idle_all(); cycle(); cycle();
        chk("abort_nohalt", 64'(obs_halt[0]), 64'd0);

        // Reset out of HALTED, then wrap the 4-bit counter: 15 + 2 -> 1.
        do_reset();
        chk("rst_halt", 64'(obs_halt[2]), 64'd0);
        chk("rst_hpc", 64'(obs_hpc[2]), 64'd0);
        chk("rst_base", obs_base[2], 64'd0);
        for (int k = 0; k < 7; k++) begin
            idle_all(); put(2, 0, 32'h500, 1'b0); put(2, 1, 32'h504, 1'b0); cycle();
        end
        idle_all(); put(2, 0, 32'h500, 1'b0); cycle();
        chk("wrap_pre", obs_base[2], 64'd15);
        idle_all(); put(2, 0, 32'h500, 1'b0); put(2, 1, 32'h504, 1'b0); cycle();
        chk("wrap_post", obs_base[2], 64'd1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < c_NI; i++)
                for (int c = 0; c < 4; c++) begin
                    v[i][c]  = ($urandom_range(0, 3) != 0);
                    rd[i][c] = 32'h80 + 32'($urandom_range(0, 15)) * 4;
                    wd[i][c] = ($urandom_range(0, 1) == 1) ? rd[i][c] : rd[i][c] + 32'd4;
                end
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvfi_commit_monitor.md
Name: rvfi_commit_monitor

Overview:
- Parametrised, synthesizable commit monitor for the RVFI path. It replaces the fixed two-flop halt delay and the single-channel order counter.
- Accepts up to NUM_CH retirements per cycle and assigns a monotonically increasing order to each one.
- Detects a committed jump-to-self (pc_wdata == pc_rdata), requires HALT_CONFIRM consecutive occurrences, then asserts a sticky halt after a programmable delay.
- Sits between the CPU retire stage and the rvfi interface in the testbench top.

Parameters:
- NUM_CH, 1, commit channels per cycle; channel index = program order, 0 oldest.
- XLEN, 32, PC width.
- ORDER_W, 64, width of the order counter.
- HALT_CONFIRM, 1, consecutive self-loop commits required to arm halt (>=1).
- HALT_DELAY, 2, cycles between arming and halt assertion (>=0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  NUM_CH  per-channel retirement strobe
- pc_rdata  in  NUM_CH*XLEN  PC of each retiring instruction, channel c at [c*XLEN +: XLEN]
- pc_wdata  in  NUM_CH*XLEN  next PC of each retiring instruction
- order  out  NUM_CH*ORDER_W  per-channel order, combinational
- order_base  out  ORDER_W  registered count of all commits so far
- armed  out  1  delay phase in progress
- halt  out  1  sticky halt indication
- halt_pc  out  XLEN  PC of the self-loop instruction that caused halt

Behaviour:
- One clock domain, clk. rst is synchronous and active-high.
- Reset values: order_base=0, confirm count=0, state=RUN, halt=0, armed=0, halt_pc=0. rst asserted in any state, including ARMED and HALTED, returns to these values at the next edge.
- Order numbering:
  - order[c] = order_base + popcount(commit_valid[c-1:0]). The output is valid regardless of commit_valid[c].
  - At each edge, order_base += popcount(commit_valid).
  - Arithmetic is modulo 2^ORDER_W; wrap from all-ones to 0 is silent.
  - Counting continues in every state, including HALTED.
- Cycle classification (only when any commit_valid is set):
  - The deciding channel is the highest-index valid channel, because it is last in program order.
  - The cycle is a LOOP if pc_wdata == pc_rdata on that channel; otherwise it is a NONLOOP.
  - Cycles with no valid commit are IDLE; they are stall-transparent and change nothing.
- Confirm counter (state RUN only), width clog2(HALT_CONFIRM+1):
  - LOOP increments it and latches a candidate PC from the deciding channel.
  - NONLOOP clears it to 0.
  - IDLE holds it.
- FSM states: RUN, ARMED, HALTED.
  - RUN -> ARMED when a LOOP cycle brings the count to HALT_CONFIRM and HALT_DELAY > 0. The delay counter loads HALT_DELAY-1.
  - RUN -> HALTED directly on that event when HALT_DELAY = 0.
  - ARMED: the delay counter decrements every cycle, including IDLE cycles.
  - ARMED -> RUN on a NONLOOP commit. This aborts the halt; the count clears and the delay counter clears.
  - ARMED -> HALTED when the delay counter is 0 and there is no NONLOOP commit that cycle. An abort in the same cycle wins.
  - HALTED is absorbing until rst.
- Timing: let the confirming LOOP commit be sampled at edge E0.
  - armed=1 from E0 to E0+HALT_DELAY.
  - halt=1 from edge E0+HALT_DELAY onward, i.e. HALT_DELAY cycles after armed rises.
  - With HALT_DELAY=0, halt rises at E0 and armed never asserts.
- halt_pc loads the candidate PC at the edge where halt rises and holds afterwards.
- armed and halt are registered and never high together.
- Lengths/indices: NUM_CH=1 reduces popcount to commit_valid[0]. The order output of channel 0 is always order_base.

Test Plan:
- Reset, then 5 single-channel commits with pc_wdata=pc_rdata+4 -> order = 0,1,2,3,4; order_base = 5; halt = 0.
- NUM_CH=4, commit_valid=4'b1011 with order_base=10 -> order[0]=10, order[1]=11, order[3]=12; order_base becomes 13 next cycle.
- Defaults: one LOOP commit at pc 0x0000_0060 -> armed high for 2 cycles, then halt=1 with halt_pc=0x0000_0060 and armed=0. Insert 3 idle cycles before the LOOP -> same result.
- HALT_CONFIRM=3: LOOP, LOOP, NONLOOP, LOOP, LOOP, LOOP -> count goes 1, 2, 0, 1, 2, 3; armed only after the 6th commit.
- Defaults: LOOP, then a NONLOOP in the next cycle while armed -> armed drops, halt stays 0. Same cycle: a NONLOOP on a lower channel with a LOOP on a higher channel -> the cycle counts as LOOP.
- Preload order_base=2^64-1, commit 2 -> order_base=1. Assert rst while HALTED -> halt=0, order_base=0, halt_pc=0 next cycle.
